// File: rtl/final_project_fb_arbiter.sv
// Framebuffer write-port arbiter for the draw, play and erase engines.
// Erase has absolute priority; draw and play share round-robin with a burst cap.
module final_project_fb_arbiter #(
    parameter int H_RES     = 160,
    parameter int V_RES     = 120,
    parameter int X_W       = 8,
    parameter int Y_W       = 7,
    parameter int COLOR_W   = 3,
    parameter int ADDR_W    = 15,
    parameter int MAX_BURST = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en_draw,
    input  logic                 en_play,
    input  logic                 en_erase,
    input  logic [2:0]           req,
    input  logic [3*X_W-1:0]     x_in,
    input  logic [3*Y_W-1:0]     y_in,
    input  logic [3*COLOR_W-1:0] color_in,
    output logic [2:0]           grant,
    output logic [2:0]           ack,
    output logic                 fb_we,
    output logic [ADDR_W-1:0]    fb_addr,
    output logic [COLOR_W-1:0]   fb_data,
    output logic                 busy
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
    localparam logic [ADDR_W-1:0] H_RES_A = ADDR_W'(H_RES);
    localparam logic [X_W:0] X_LIM = (X_W + 1)'(H_RES);
    localparam logic [Y_W:0] Y_LIM = (Y_W + 1)'(V_RES);

    typedef enum logic [1:0] {
        IDLE,
        OWN,
        SWITCH
    } state_t;

    state_t           state;
    logic [1:0]       owner;
    logic             rr_last;
    logic [CNT_W-1:0] burst_cnt;

    logic [2:0]         elig;
    logic [X_W-1:0]     x_sel;
    logic [Y_W-1:0]     y_sel;
    logic [COLOR_W-1:0] c_sel;
    logic [ADDR_W-1:0]  addr_calc;
    logic [CNT_W-1:0]   cnt_next;
    logic [1:0]         win;
    logic               own_elig;
    logic               others;
    logic               at_max;
    logic               leave;
    logic               in_range;

    assign busy = (state != IDLE);

    always_comb begin
        elig = req & {en_erase, en_play, en_draw};
        ack  = grant & elig;
        x_sel = '0;
        y_sel = '0;
        c_sel = '0;
        for (int i = 0; i < 3; i++) begin
            if (grant[i]) begin
                x_sel = x_in[i*X_W +: X_W];
                y_sel = y_in[i*Y_W +: Y_W];
                c_sel = color_in[i*COLOR_W +: COLOR_W];
            end
        end
        in_range  = ({1'b0, x_sel} < X_LIM) && ({1'b0, y_sel} < Y_LIM);
        addr_calc = ADDR_W'(y_sel) * H_RES_A + ADDR_W'(x_sel);
    end

    always_comb begin
        own_elig = |ack;
        others   = |(elig & ~grant);
        if (!own_elig)
            cnt_next = burst_cnt;
        else if (burst_cnt == CNT_MAX)
            cnt_next = CNT_MAX;
        else
            cnt_next = burst_cnt + CNT_W'(1);
        at_max = (cnt_next == CNT_MAX);
        leave  = !own_elig
               || (!grant[2] && elig[2])
               || (at_max && others);
    end

    // rr_last set means play was the most recent draw/play owner
    always_comb begin
        if (elig[2])
            win = 2'd2;
        else if (elig[0] && (!elig[1] || rr_last))
            win = 2'd0;
        else
            win = 2'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grant     <= '0;
            owner     <= '0;
            rr_last   <= 1'b1;
            burst_cnt <= '0;
            fb_we     <= 1'b0;
            fb_addr   <= '0;
            fb_data   <= '0;
        end else begin
            fb_we <= 1'b0;
            if (own_elig) begin
                fb_we <= in_range;
                if (in_range) begin
                    fb_addr <= addr_calc;
                    fb_data <= c_sel;
                end
            end
            case (state)
                IDLE: begin
                    if (|elig) begin
                        grant     <= 3'b001 << win;
                        owner     <= win;
                        burst_cnt <= '0;
                        state     <= OWN;
                    end
                end
                OWN: begin
                    if (leave) begin
                        grant     <= '0;
                        burst_cnt <= '0;
                        state     <= SWITCH;
                    end else if (at_max) begin
                        burst_cnt <= '0;
                    end else begin
                        burst_cnt <= cnt_next;
                    end
                end
                SWITCH: begin
                    if (owner != 2'd2)
                        rr_last <= owner[0];
                    state <= IDLE;
                end
                default: begin
                    grant <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_final_project_fb_arbiter.sv
// Bench for the framebuffer arbiter: directed scenarios with literal
// expectations plus random traffic checked every cycle against a model.
module tb_final_project_fb_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en_draw = 1'b0;
    logic        en_play = 1'b0;
    logic        en_erase = 1'b0;
    logic [2:0]  req = '0;
    logic [23:0] x_in = '0;
    logic [20:0] y_in = '0;
    logic [8:0]  color_in = '0;
    logic [2:0]  grant;
    logic [2:0]  ack;
    logic        fb_we;
    logic [14:0] fb_addr;
    logic [2:0]  fb_data;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    final_project_fb_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .en_draw  (en_draw),
        .en_play  (en_play),
        .en_erase (en_erase),
        .req      (req),
        .x_in     (x_in),
        .y_in     (y_in),
        .color_in (color_in),
        .grant    (grant),
        .ack      (ack),
        .fb_we    (fb_we),
        .fb_addr  (fb_addr),
        .fb_data  (fb_data),
        .busy     (busy)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_px(input int i, input int x, input int y, input int c);
        x_in[i*8 +: 8]     = 8'(x);
        y_in[i*7 +: 7]     = 7'(y);
        color_in[i*3 +: 3] = 3'(c);
    endtask

    function automatic int pick(input logic [2:0] el, input int last);
        if (el[2]) return 2;
        if (el[0] && el[1]) return (last == 1) ? 0 : 1;
        if (el[0]) return 0;
        return 1;
    endfunction

    // Model: who owns the port, and how many dead cycles remain after a release
    int   m_owner = -1;
    int   m_cool  = 0;
    int   m_cnt   = 0;
    int   m_last  = 1;
    bit   m_valid = 0;
    logic m_we    = 1'b0;
    int   m_addr  = 0;
    int   m_data  = 0;

    always @(negedge clk) begin
        logic [2:0] el;
        logic [2:0] eg;
        logic [2:0] ea;
        int xo;
        int yo;
        el = req & {en_erase, en_play, en_draw};
        eg = (m_owner >= 0) ? 3'(1 << m_owner) : 3'b000;
        ea = eg & el;
        if (m_valid) begin
            chk("grant", 32'(grant), 32'(eg));
            chk("ack", 32'(ack), 32'(ea));
            chk("busy", 32'(busy), 32'(m_owner >= 0 || m_cool == 2));
            chk("fb_we", 32'(fb_we), 32'(m_we));
            chk("fb_addr", 32'(fb_addr), 32'(m_addr));
            chk("fb_data", 32'(fb_data), 32'(m_data));
        end
        if (rst) begin
            m_owner = -1;
            m_cool  = 0;
            m_cnt   = 0;
            m_last  = 1;
            m_we    = 1'b0;
            m_addr  = 0;
            m_data  = 0;
            m_valid = 1;
        end else begin
            m_we = 1'b0;
            if (ea != 3'b000) begin
                xo = int'(x_in[m_owner*8 +: 8]);
                yo = int'(y_in[m_owner*7 +: 7]);
                if (xo < 160 && yo < 120) begin
                    m_we   = 1'b1;
                    m_addr = yo * 160 + xo;
                    m_data = int'(color_in[m_owner*3 +: 3]);
                end
            end
            if (m_owner >= 0) begin
                if (el[m_owner]) m_cnt = (m_cnt < 16) ? m_cnt + 1 : 16;
                if (!el[m_owner] || (m_owner != 2 && el[2])
                    || (m_cnt == 16 && (el & ~eg) != 3'b000)) begin
                    if (m_owner != 2) m_last = m_owner;
                    m_owner = -1;
                    m_cool  = 2;
                    m_cnt   = 0;
                end else if (m_cnt == 16) begin
                    m_cnt = 0;
                end
            end else if (m_cool == 2) begin
                m_cool = 1;
            end else begin
                m_cool = 0;
                if (el != 3'b000) begin
                    m_owner = pick(el, m_last);
                    m_cnt   = 0;
                end
            end
        end
    end

    logic [2:0] seq [38];

    initial begin
        repeat (2) step();
        @(negedge clk);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_we", 32'(fb_we), 0);
        chk("rst_addr", 32'(fb_addr), 0);
        chk("rst_data", 32'(fb_data), 0);
        chk("rst_busy", 32'(busy), 0);

        // single draw pixel
        step();
        rst = 1'b0;
        en_draw = 1'b1;
        req = 3'b001;
        set_px(0, 5, 2, 3);
        @(negedge clk);
        chk("a_idle_grant", 32'(grant), 0);
        step();
        @(negedge clk);
        chk("a_grant", 32'(grant), 1);
        chk("a_ack", 32'(ack), 1);
        step();
        req = 3'b000;
        @(negedge clk);
        chk("a_we", 32'(fb_we), 1);
        chk("a_addr", 32'(fb_addr), 325);
        chk("a_data", 32'(fb_data), 3);
        repeat (3) step();

        // out-of-range pixel is acked but dropped
        req = 3'b001;
        set_px(0, 160, 0, 5);
        step();
        @(negedge clk);
        chk("c_ack_oor", 32'(ack), 1);
        step();
        set_px(0, 159, 119, 6);
        @(negedge clk);
        chk("c_ack2", 32'(ack), 1);
        chk("c_we_drop", 32'(fb_we), 0);
        chk("c_addr_hold", 32'(fb_addr), 325);
        step();
        req = 3'b000;
        @(negedge clk);
        chk("c_we", 32'(fb_we), 1);
        chk("c_addr_max", 32'(fb_addr), 19199);
        chk("c_data", 32'(fb_data), 6);
        repeat (3) step();

        // draw/play bursts from a fresh reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        en_draw = 1'b1;
        en_play = 1'b1;
        req = 3'b011;
        set_px(0, 10, 10, 1);
        set_px(1, 20, 20, 2);
        for (int k = 0; k < 38; k++) begin
            @(negedge clk);
            seq[k] = ack;
            step();
        end
        chk("b_ack0", 32'(seq[0]), 0);
        chk("b_ack1", 32'(seq[1]), 1);
        chk("b_ack16", 32'(seq[16]), 1);
        chk("b_ack17", 32'(seq[17]), 0);
        chk("b_ack18", 32'(seq[18]), 0);
        chk("b_ack19", 32'(seq[19]), 2);
        chk("b_ack34", 32'(seq[34]), 2);
        chk("b_ack35", 32'(seq[35]), 0);
        chk("b_ack36", 32'(seq[36]), 0);
        chk("b_ack37", 32'(seq[37]), 1);

        // erase preempts draw mid-burst
        en_erase = 1'b1;
        req = 3'b101;
        set_px(2, 1, 1, 7);
        @(negedge clk);
        chk("d_ack_t", 32'(ack), 1);
        step();
        @(negedge clk);
        chk("d_grant_t1", 32'(grant), 0);
        chk("d_ack_t1", 32'(ack), 0);
        step();
        @(negedge clk);
        chk("d_busy_t2", 32'(busy), 0);
        step();
        @(negedge clk);
        chk("d_grant_t3", 32'(grant), 4);
        chk("d_ack_t3", 32'(ack), 4);
        step();
        req = 3'b000;
        en_erase = 1'b0;
        en_play = 1'b0;
        @(negedge clk);
        chk("d_addr", 32'(fb_addr), 161);
        chk("d_data", 32'(fb_data), 7);
        repeat (2) step();

        // disable draw mid-burst
        req = 3'b001;
        step();
        @(negedge clk);
        chk("e_ack", 32'(ack), 1);
        step();
        en_draw = 1'b0;
        @(negedge clk);
        chk("e_ack_off", 32'(ack), 0);
        step();
        @(negedge clk);
        chk("e_grant_rel", 32'(grant), 0);
        step();

        // reset during a play burst
        en_play = 1'b1;
        req = 3'b010;
        set_px(1, 3, 4, 5);
        repeat (4) step();
        @(negedge clk);
        chk("f_ack", 32'(ack), 2);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("f_grant", 32'(grant), 0);
        chk("f_ack0", 32'(ack), 0);
        chk("f_we", 32'(fb_we), 0);
        chk("f_addr", 32'(fb_addr), 0);
        chk("f_data", 32'(fb_data), 0);
        chk("f_busy", 32'(busy), 0);
        step();
        @(negedge clk);
        chk("f_regrant", 32'(grant), 2);

        // random traffic with long request runs so bursts reach the cap
        en_draw = 1'b1;
        en_play = 1'b1;
        for (int n = 0; n < 4000; n++) begin
            step();
            rst = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < 2; i++) begin
                if ($urandom_range(0, 11) == 0) req[i] = ~req[i];
            end
            if (req[2]) req[2] = ($urandom_range(0, 5) != 0);
            else req[2] = ($urandom_range(0, 39) == 0);
            if (en_draw) en_draw = ($urandom_range(0, 49) != 0);
            else en_draw = ($urandom_range(0, 2) == 0);
            if (en_play) en_play = ($urandom_range(0, 49) != 0);
            else en_play = ($urandom_range(0, 2) == 0);
            if (en_erase) en_erase = ($urandom_range(0, 49) != 0);
            else en_erase = ($urandom_range(0, 2) == 0);
            for (int i = 0; i < 3; i++) begin
                set_px(i, int'($urandom_range(0, 169)),
                       int'($urandom_range(0, 127)),
                       int'($urandom_range(0, 7)));
            end
        end
        rst = 1'b0;
        req = 3'b000;
        repeat (4) step();
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
